dmem_arbiter: RTL and testbench

//  Shares the single data-memory port between two requesters: port 0 = core load/store
//  (ALUResult/storeOut/DQM path), port 1 = loader/debug DMA. Valid/ready request

---
 rtl/dmem_arb_pkg.sv | 30 +++
 rtl/dmem_arbiter_rr_arb2.sv | 24 ++
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// No logic of its own; widths here bound the legal read latency range (1..4).
// No flow control of its own; the arbiter consumes these definitions.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  // Access size codes carried on the dqm lines
  localparam logic [1:0] DQM_BYTE = 2'b00;
  localparam logic [1:0] DQM_HALF = 2'b01;
  localparam logic [1:0] DQM_WORD = 2'b10;

  // Requester identities, also the encoding of grant_id
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  // lat_cnt holds RD_LAT-1 at most, RD_LAT <= 4
  localparam int LAT_W = 2;

  // Non-address part of a memory command, muxed as one bundle
  typedef struct packed {
    logic        we;
    logic [31:0] wdata;
    logic [1:0]  dqm;
  } mem_cmd_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way pick between requesters, one-hot grant.
// Latency: purely combinational.
// Backpressure: none here; the caller gates the grant with its own accept window.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  input  logic       prio_fixed,
  output logic [1:0] grant
);

  // On contention: fixed mode always picks port 0, otherwise the port not served last
  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = (prio_fixed || last_grant) ? 2'b01 : 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core (port 0) and loader/DMA (port 1).
// Latency: memory command is combinational in the accept cycle; read data returns RD_LAT cycles later.
// Backpressure: the losing port, and both ports while a multi-cycle read is outstanding, see req_ready=0.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int RD_LAT  = 1,
  parameter int PRIO_M0 = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req_valid,
  output logic          m0_req_ready,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [1:0]    m0_dqm,
  output logic          m0_rsp_valid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req_valid,
  output logic          m1_req_ready,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [1:0]    m1_dqm,
  output logic          m1_rsp_valid,
  output logic [31:0]   m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  output logic [1:0]    mem_dqm,
  input  logic [31:0]   mem_rdata,
  output logic          grant_id
);

  localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(RD_LAT - 1);
  localparam logic             PRIO_FIXED = (PRIO_M0 != 0);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_owner_q, rsp_owner_d;
  logic             rsp_pend_q, rsp_pend_d;

  logic [1:0] grant;
  logic       accept_en, win0, win1, accept, win_id, rsp_fire;
  mem_cmd_t   cmd0, cmd1, cmd_win;

  rr_arb2 u_rr_arb2 (
    .valid0    (m0_req_valid),
    .valid1    (m1_req_valid),
    .last_grant(last_grant_q),
    .prio_fixed(PRIO_FIXED),
    .grant     (grant)
  );

  // Accept window: IDLE and out of reset, so nothing leaks out while rst is held low
  assign accept_en = (state_q == IDLE) && rst;
  assign win0      = accept_en && grant[0];
  assign win1      = accept_en && grant[1];
  assign accept    = win0 || win1;
  assign win_id    = win1;

  // A pending read returns once the latency counter has run down
  assign rsp_fire  = rsp_pend_q && (lat_cnt_q == '0);

  assign cmd0 = '{we: m0_we, wdata: m0_wdata, dqm: m0_dqm};
  assign cmd1 = '{we: m1_we, wdata: m1_wdata, dqm: m1_dqm};

  // Memory command follows the winner in the accept cycle only, zero otherwise
  always_comb begin
    cmd_win  = '0;
    mem_addr = '0;
    if (win0) begin
      cmd_win  = cmd0;
      mem_addr = m0_addr;
    end else if (win1) begin
      cmd_win  = cmd1;
      mem_addr = m1_addr;
    end
  end

  assign mem_we    = cmd_win.we;
  assign mem_wdata = cmd_win.wdata;
  assign mem_dqm   = cmd_win.dqm;

  assign m0_req_ready = win0;
  assign m1_req_ready = win1;

  // Response is steered by the registered owner, so a new accept in the same cycle cannot redirect it
  assign m0_rsp_valid = rsp_fire && (rsp_owner_q == PORT_CORE);
  assign m1_rsp_valid = rsp_fire && (rsp_owner_q == PORT_DMA);
  assign m0_rdata     = m0_rsp_valid ? mem_rdata : '0;
  assign m1_rdata     = m1_rsp_valid ? mem_rdata : '0;

  // New winner when accepting; the reader keeps ownership while its data is in flight
  assign grant_id = accept ? win_id : ((state_q == RD_WAIT) ? rsp_owner_q : 1'b0);

  // Next state: record the accept, arm the latency counter for reads, count it down in RD_WAIT
  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    last_grant_d = last_grant_q;
    rsp_owner_d  = rsp_owner_q;
    rsp_pend_d   = rsp_pend_q;
    if (rsp_fire) begin
      rsp_pend_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          last_grant_d = win_id;
          if (!cmd_win.we) begin
            rsp_pend_d  = 1'b1;
            rsp_owner_d = win_id;
            lat_cnt_d   = LAT_INIT;
            state_d     = (RD_LAT == 1) ? IDLE : RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        lat_cnt_d = lat_cnt_q - 1'b1;
        if (lat_cnt_q == LAT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any read in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      last_grant_q <= PORT_DMA;
      rsp_owner_q  <= PORT_CORE;
      rsp_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      last_grant_q <= last_grant_d;
      rsp_owner_q  <= rsp_owner_d;
      rsp_pend_q   <= rsp_pend_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       rst;
  logic [N-1:0]       m0_req_valid, m0_req_ready, m0_we, m0_rsp_valid;
  logic [N-1:0]       m1_req_valid, m1_req_ready, m1_we, m1_rsp_valid;
  logic [N-1:0][31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [N-1:0][1:0]  m0_dqm, m1_dqm, mem_dqm;
  logic [N-1:0][31:0] mem_addr, mem_wdata, mem_rdata;
  logic [N-1:0]       mem_we, grant_id;
  logic               mem_clr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          cyc;
    logic        port;
    logic [31:0] data;
  } rsp_t;

  // Instance 0: RD_LAT=1 RR, 1: RD_LAT=2 RR, 2: RD_LAT=3 RR, 3: RD_LAT=1 fixed priority
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT  = (g == 1) ? 2 : ((g == 2) ? 3 : 1);
    localparam int PRIO = (g == 3) ? 1 : 0;

    dmem_arbiter #(.AW(32), .RD_LAT(LAT), .PRIO_M0(PRIO)) u_dut (
      .clk(clk), .rst(rst[g]),
      .m0_req_valid(m0_req_valid[g]), .m0_req_ready(m0_req_ready[g]), .m0_we(m0_we[g]),
      .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]), .m0_dqm(m0_dqm[g]),
      .m0_rsp_valid(m0_rsp_valid[g]), .m0_rdata(m0_rdata[g]),
      .m1_req_valid(m1_req_valid[g]), .m1_req_ready(m1_req_ready[g]), .m1_we(m1_we[g]),
      .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]), .m1_dqm(m1_dqm[g]),
      .m1_rsp_valid(m1_rsp_valid[g]), .m1_rdata(m1_rdata[g]),
      .mem_addr(mem_addr[g]), .mem_we(mem_we[g]), .mem_wdata(mem_wdata[g]),
      .mem_dqm(mem_dqm[g]), .mem_rdata(mem_rdata[g]), .grant_id(grant_id[g])
    );

    // Data memory stand-in: address captured every cycle, data appears LAT cycles later
    logic [31:0] mem [256];
    logic [7:0]  dly [4];
    always_ff @(posedge clk) begin
      if (mem_clr) begin
        for (int i = 0; i < 256; i++) mem[i] <= '0;
      end else if (mem_we[g]) begin
        mem[mem_addr[g][7:0]] <= mem_wdata[g];
      end
      dly[0] <= mem_addr[g][7:0];
      for (int i = 1; i < 4; i++) dly[i] <= dly[i-1];
    end
    assign mem_rdata[g] = mem[dly[LAT-1]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int g, input int p, input logic v, input logic we,
                     input logic [31:0] a, input logic [31:0] d, input logic [1:0] q);
    if (p == 0) begin
      m0_req_valid[g] = v; m0_we[g] = we; m0_addr[g] = a; m0_wdata[g] = d; m0_dqm[g] = q;
    end else begin
      m1_req_valid[g] = v; m1_we[g] = we; m1_addr[g] = a; m1_wdata[g] = d; m1_dqm[g] = q;
    end
  endtask

  task automatic idle(input int g);
    drv(g, 0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    drv(g, 1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
  endtask

  task automatic test_reset();
    for (int g = 0; g < N; g++) begin
      drv(g, 0, 1'b1, 1'b1, 32'h4, 32'h1, DQM_WORD);
      drv(g, 1, 1'b1, 1'b0, 32'h8, 32'h2, DQM_HALF);
    end
    @(negedge clk);
    n_checks++;
    if ({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, mem_we, grant_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%h required=0",
               {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, mem_we, grant_id});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, mem_dqm, m0_rdata, m1_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got=%h required=0", {mem_addr, mem_wdata, mem_dqm, m0_rdata, m1_rdata});
    end
    step();
    for (int g = 0; g < N; g++) idle(g);
    rst     = '1;
    mem_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, mem_we, mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset got=%h required=0",
               {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, mem_we, mem_addr});
    end
    step();
  endtask

  task automatic test_single_read();
    drv(1, 1, 1'b1, 1'b1, 32'h10, 32'h12345678, DQM_WORD);
    @(negedge clk);
    n_checks++;
    if ({m1_req_ready[1], mem_we[1]} !== 2'b11) begin
      n_fail++; $display("FAIL sr_preload got=%b required=11", {m1_req_ready[1], mem_we[1]});
    end
    step();
    drv(1, 1, 1'b0, 1'b0, 32'h0, 32'h0, DQM_WORD);
    drv(1, 0, 1'b1, 1'b0, 32'h10, 32'h0, DQM_WORD);
    @(negedge clk); // T
    n_checks++;
    if ({m0_req_ready[1], mem_we[1], grant_id[1], mem_addr[1]} !== {3'b100, 32'h10}) begin
      n_fail++;
      $display("FAIL sr_accept got=%b/%b/%b/%h required=1/0/0/10",
               m0_req_ready[1], mem_we[1], grant_id[1], mem_addr[1]);
    end
    step();
    drv(1, 0, 1'b0, 1'b0, 32'h0, 32'h0, DQM_WORD);
    drv(1, 1, 1'b1, 1'b0, 32'h14, 32'h0, DQM_WORD);
    @(negedge clk); // T+1
    n_checks++;
    if ({m1_req_ready[1], m0_rsp_valid[1]} !== 2'b00) begin
      n_fail++; $display("FAIL sr_wait got=%b required=00", {m1_req_ready[1], m0_rsp_valid[1]});
    end
    step();
    @(negedge clk); // T+2
    n_checks++;
    if ({m0_rsp_valid[1], m1_rsp_valid[1], m0_rdata[1], m1_rdata[1]} !== {2'b10, 32'h12345678, 32'h0}) begin
      n_fail++;
      $display("FAIL sr_rsp got=%b%b rdata0=%h rdata1=%h required=10 12345678 0",
               m0_rsp_valid[1], m1_rsp_valid[1], m0_rdata[1], m1_rdata[1]);
    end
    n_checks++;
    if ({m1_req_ready[1], grant_id[1]} !== 2'b11) begin
      n_fail++; $display("FAIL sr_accept_in_rsp got=%b required=11", {m1_req_ready[1], grant_id[1]});
    end
    step();
    drv(1, 1, 1'b0, 1'b0, 32'h0, 32'h0, DQM_WORD);
    @(negedge clk); // T+3
    n_checks++;
    if (m0_rsp_valid[1] !== 1'b0) begin
      n_fail++; $display("FAIL sr_single_pulse got=%b required=0", m0_rsp_valid[1]);
    end
    step();
    @(negedge clk); // T+4
    n_checks++;
    if ({m0_rsp_valid[1], m1_rsp_valid[1]} !== 2'b01) begin
      n_fail++; $display("FAIL sr_m1_rsp got=%b required=01", {m0_rsp_valid[1], m1_rsp_valid[1]});
    end
    step();
  endtask

  task automatic test_reset_mid_read();
    drv(2, 0, 1'b1, 1'b0, 32'h30, 32'h0, DQM_WORD);
    @(negedge clk); // T
    n_checks++;
    if (m0_req_ready[2] !== 1'b1) begin
      n_fail++; $display("FAIL rmr_accept got=%b required=1", m0_req_ready[2]);
    end
    step();
    drv(2, 0, 1'b1, 1'b1, 32'h34, 32'hA5, DQM_WORD);
    drv(2, 1, 1'b1, 1'b1, 32'h38, 32'h5A, DQM_WORD);
    rst[2] = 1'b0;
    @(negedge clk); // T+1, in reset
    n_checks++;
    if ({m0_req_ready[2], m1_req_ready[2], m0_rsp_valid[2], m1_rsp_valid[2], mem_we[2], grant_id[2],
         mem_addr[2], mem_wdata[2], mem_dqm[2], m0_rdata[2], m1_rdata[2]} !== '0) begin
      n_fail++;
      $display("FAIL rmr_outputs got=%b%b%b%b%b%b %h %h %b", m0_req_ready[2], m1_req_ready[2],
               m0_rsp_valid[2], m1_rsp_valid[2], mem_we[2], grant_id[2], mem_addr[2], mem_wdata[2], mem_dqm[2]);
    end
    step();
    step();
    rst[2] = 1'b1;
    @(negedge clk); // T+3: the dropped read would have returned here
    n_checks++;
    if ({grant_id[2], m0_req_ready[2], m1_req_ready[2], m0_rsp_valid[2]} !== 4'b0100) begin
      n_fail++;
      $display("FAIL rmr_first_grant got=%b required=0100",
               {grant_id[2], m0_req_ready[2], m1_req_ready[2], m0_rsp_valid[2]});
    end
    step();
    idle(2);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (m0_rsp_valid[2] !== 1'b0) begin
        n_fail++; $display("FAIL rmr_no_rsp cycle=%0d got=%b required=0", k, m0_rsp_valid[2]);
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    logic        eg;
    logic [31:0] ea;
    drv(0, 0, 1'b1, 1'b1, 32'h40, 32'hA0A0, DQM_WORD);
    drv(0, 1, 1'b1, 1'b1, 32'h44, 32'hB1B1, DQM_WORD);
    for (int k = 0; k < 4; k++) begin
      eg = (k % 2 == 1);
      ea = eg ? 32'h44 : 32'h40;
      @(negedge clk);
      n_checks++;
      if ({grant_id[0], mem_we[0], mem_addr[0], m1_req_ready[0], m0_req_ready[0]} !== {eg, 1'b1, ea, eg, ~eg}) begin
        n_fail++;
        $display("FAIL rr_grant k=%0d got=%b/%b/%h/%b%b required=%b/1/%h/%b%b", k, grant_id[0], mem_we[0],
                 mem_addr[0], m1_req_ready[0], m0_req_ready[0], eg, ea, eg, ~eg);
      end
      step();
    end
    idle(0);
  endtask

  task automatic test_fixed_prio();
    drv(3, 0, 1'b1, 1'b1, 32'h60, 32'h6060, DQM_WORD);
    drv(3, 1, 1'b1, 1'b1, 32'h64, 32'h6464, DQM_WORD);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if ({m0_req_ready[3], m1_req_ready[3]} !== 2'b10) begin
        n_fail++; $display("FAIL prio_m0_wins k=%0d got=%b required=10", k, {m0_req_ready[3], m1_req_ready[3]});
      end
      step();
    end
    drv(3, 0, 1'b0, 1'b0, 32'h0, 32'h0, DQM_WORD);
    @(negedge clk);
    n_checks++;
    if ({m1_req_ready[3], grant_id[3], mem_addr[3]} !== {2'b11, 32'h64}) begin
      n_fail++;
      $display("FAIL prio_m1_after got=%b/%b/%h required=1/1/64", m1_req_ready[3], grant_id[3], mem_addr[3]);
    end
    step();
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd [4];
    for (int k = 0; k < 4; k++) begin
      wd[k] = $urandom;
      drv(0, 1, 1'b1, 1'b1, 32'h50 + 32'(k), wd[k], DQM_WORD);
      @(negedge clk);
      n_checks++;
      if ({m1_req_ready[0], mem_we[0]} !== 2'b11) begin
        n_fail++; $display("FAIL b2b_write k=%0d got=%b required=11", k, {m1_req_ready[0], mem_we[0]});
      end
      step();
    end
    drv(0, 1, 1'b0, 1'b0, 32'h0, 32'h0, DQM_WORD);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drv(0, 0, 1'b1, 1'b0, 32'h50 + 32'(k), 32'h0, DQM_WORD);
      else       drv(0, 0, 1'b0, 1'b0, 32'h0, 32'h0, DQM_WORD);
      @(negedge clk);
      if (k < 4) begin
        n_checks++;
        if (m0_req_ready[0] !== 1'b1) begin
          n_fail++; $display("FAIL b2b_read_accept k=%0d got=%b required=1", k, m0_req_ready[0]);
        end
      end
      if (k > 0) begin
        n_checks++;
        if ({m0_rsp_valid[0], m0_rdata[0]} !== {1'b1, wd[k-1]}) begin
          n_fail++;
          $display("FAIL b2b_rsp k=%0d got=%b/%h required=1/%h", k, m0_rsp_valid[0], m0_rdata[0], wd[k-1]);
        end
      end
      step();
    end
    @(negedge clk);
    n_checks++;
    if (m0_rsp_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end got=%b required=0", m0_rsp_valid[0]);
    end
    step();
  endtask

  task automatic test_write_readback();
    drv(0, 1, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, DQM_WORD);
    @(negedge clk);
    n_checks++;
    if ({mem_we[0], mem_addr[0], mem_wdata[0], mem_dqm[0]} !== {1'b1, 32'h20, 32'hDEADBEEF, 2'b10}) begin
      n_fail++;
      $display("FAIL wrb_write got=%b/%h/%h/%b required=1/20/deadbeef/10",
               mem_we[0], mem_addr[0], mem_wdata[0], mem_dqm[0]);
    end
    step();
    drv(0, 1, 1'b0, 1'b0, 32'h0, 32'h0, DQM_WORD);
    drv(0, 0, 1'b1, 1'b0, 32'h20, 32'h0, DQM_WORD);
    @(negedge clk);
    n_checks++;
    if (m0_req_ready[0] !== 1'b1) begin
      n_fail++; $display("FAIL wrb_read_accept got=%b required=1", m0_req_ready[0]);
    end
    step();
    idle(0);
    @(negedge clk);
    n_checks++;
    if ({m0_rsp_valid[0], m1_rsp_valid[0], m0_rdata[0], m1_rdata[0]} !== {2'b10, 32'hDEADBEEF, 32'h0}) begin
      n_fail++;
      $display("FAIL wrb_rsp got=%b%b %h %h required=10 deadbeef 0",
               m0_rsp_valid[0], m1_rsp_valid[0], m0_rdata[0], m1_rdata[0]);
    end
    step();
    @(negedge clk);
    n_checks++;
    if ({m0_rsp_valid[0], m1_rsp_valid[0]} !== 2'b00) begin
      n_fail++; $display("FAIL wrb_quiet got=%b required=00", {m0_rsp_valid[0], m1_rsp_valid[0]});
    end
    step();
  endtask

  // Random traffic on the RD_LAT=2 round-robin instance against a timestamped model
  task automatic test_random();
    rsp_t        exp_q [$];
    rsp_t        r;
    logic [31:0] ref_mem [16];
    logic        hold [2];
    logic        lg, v0, v1, we, ev0, ev1;
    logic [31:0] a, wd, ed;
    int          free_at, win;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    rst[1] = 1'b0;
    step();
    rst[1]  = 1'b1;
    lg      = 1'b1;
    free_at = 0;
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!hold[p]) begin
          if (k >= 390) drv(1, p, 1'b0, 1'b0, 32'h0, 32'h0, DQM_WORD);
          else drv(1, p, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                   32'h80 + 32'($urandom_range(0, 15)), $urandom, DQM_WORD);
        end
      end
      @(negedge clk);
      v0  = m0_req_valid[1];
      v1  = m1_req_valid[1];
      win = -1;
      if (k >= free_at) begin
        if (v0 && v1) win = lg ? 0 : 1;
        else if (v0)  win = 0;
        else if (v1)  win = 1;
      end
      n_checks++;
      if ({m1_req_ready[1], m0_req_ready[1]} !== {(win == 1), (win == 0)}) begin
        n_fail++;
        $display("FAIL rnd_ready k=%0d got=%b%b required=%b%b", k, m1_req_ready[1], m0_req_ready[1],
                 (win == 1), (win == 0));
      end
      ev0 = 1'b0; ev1 = 1'b0; ed = '0;
      if (exp_q.size() > 0 && exp_q[0].cyc == k) begin
        r   = exp_q.pop_front();
        ev0 = (r.port == 1'b0);
        ev1 = (r.port == 1'b1);
        ed  = r.data;
      end
      n_checks++;
      if ({m0_rsp_valid[1], m1_rsp_valid[1], m0_rdata[1], m1_rdata[1]} !==
          {ev0, ev1, (ev0 ? ed : 32'h0), (ev1 ? ed : 32'h0)}) begin
        n_fail++;
        $display("FAIL rnd_rsp k=%0d got=%b%b %h %h required=%b%b %h", k, m0_rsp_valid[1], m1_rsp_valid[1],
                 m0_rdata[1], m1_rdata[1], ev0, ev1, ed);
      end
      if (win >= 0) begin
        a  = (win == 1) ? m1_addr[1]  : m0_addr[1];
        we = (win == 1) ? m1_we[1]    : m0_we[1];
        wd = (win == 1) ? m1_wdata[1] : m0_wdata[1];
        n_checks++;
        if ({mem_we[1], mem_addr[1], grant_id[1]} !== {we, a, (win == 1)}) begin
          n_fail++;
          $display("FAIL rnd_mem k=%0d got=%b/%h/%b required=%b/%h/%b", k, mem_we[1], mem_addr[1],
                   grant_id[1], we, a, (win == 1));
        end
        lg = (win == 1);
        if (we) begin
          ref_mem[a[3:0]] = wd;
        end else begin
          r.cyc  = k + 2;
          r.port = (win == 1);
          r.data = ref_mem[a[3:0]];
          exp_q.push_back(r);
          free_at = k + 2;
        end
      end
      hold[0] = v0 && (win != 0);
      hold[1] = v1 && (win != 1);
      step();
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rnd_drain got=%0d outstanding required=0", exp_q.size());
    end
  endtask

  initial begin
    rst     = '0;
    mem_clr = 1'b1;
    for (int g = 0; g < N; g++) idle(g);
    step();
    test_reset();
    test_single_read();
    test_reset_mid_read();
    test_round_robin();
    test_fixed_prio();
    test_back_to_back();
    test_write_readback();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
